// File: rtl/video_pipeline_pkg.sv
// Shared constants for the video pipeline: port identities and default bus/chunk geometry.
// Latency and backpressure: not applicable (declarations only).
package video_pipeline_pkg;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  localparam int REQUEST_BITS_DEFAULT    = 32;
  localparam int BITS_PER_PIXEL_DEFAULT  = 16;
  localparam int CHUNK_BITS_DEFAULT      = 5;
  localparam int MAX_OUTSTANDING_DEFAULT = 4;

endpackage

// File: rtl/video_scaler_port_arbiter_if.sv
// Consumer FIFO ports A/B plus the scaler's downstream request/response side, as seen by the arbiter.
// Latency and backpressure: defined by the arbiter; master = arbiter, slave = consumers and scaler.
interface video_scaler_port_arbiter_if
  import video_pipeline_pkg::*;
#(
  parameter int REQUEST_BITS   = REQUEST_BITS_DEFAULT,
  parameter int BITS_PER_PIXEL = BITS_PER_PIXEL_DEFAULT
);

  logic                      portAReqReadEnable;
  logic                      portAReqEmpty;
  logic [REQUEST_BITS-1:0]   portAReqReadData;
  logic                      portARespWriteEnable;
  logic                      portARespFull;
  logic [BITS_PER_PIXEL-1:0] portARespWriteData;

  logic                      portBReqReadEnable;
  logic                      portBReqEmpty;
  logic [REQUEST_BITS-1:0]   portBReqReadData;
  logic                      portBRespWriteEnable;
  logic                      portBRespFull;
  logic [BITS_PER_PIXEL-1:0] portBRespWriteData;

  logic                      scalerReqReadEnable;
  logic                      scalerReqEmpty;
  logic [REQUEST_BITS-1:0]   scalerReqReadData;
  logic                      scalerRespWriteEnable;
  logic                      scalerRespFull;
  logic [BITS_PER_PIXEL-1:0] scalerRespWriteData;

  modport master (
    output portAReqReadEnable, input portAReqEmpty, input portAReqReadData,
    output portARespWriteEnable, input portARespFull, output portARespWriteData,
    output portBReqReadEnable, input portBReqEmpty, input portBReqReadData,
    output portBRespWriteEnable, input portBRespFull, output portBRespWriteData,
    input scalerReqReadEnable, output scalerReqEmpty, output scalerReqReadData,
    input scalerRespWriteEnable, output scalerRespFull, input scalerRespWriteData
  );

  modport slave (
    input portAReqReadEnable, output portAReqEmpty, output portAReqReadData,
    input portARespWriteEnable, output portARespFull, input portARespWriteData,
    input portBReqReadEnable, output portBReqEmpty, output portBReqReadData,
    input portBRespWriteEnable, output portBRespFull, input portBRespWriteData,
    output scalerReqReadEnable, input scalerReqEmpty, input scalerReqReadData,
    output scalerRespWriteEnable, input scalerRespFull, output scalerRespWriteData
  );

endinterface

// File: rtl/scaler_owner_tag_fifo.sv
// 1-bit owner-tag FIFO recording which port each in-flight scaler request belongs to.
// Latency: push visible at head next cycle; no backpressure (caller never pushes when full).
module scaler_owner_tag_fifo
  import video_pipeline_pkg::*;
#(
  parameter int DEPTH = MAX_OUTSTANDING_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic push,
  input  logic pushTag,
  input  logic pop,
  output logic full,
  output logic empty,
  output logic head
);

  localparam int PTR_BITS = $clog2(DEPTH);

  logic [DEPTH-1:0]    tagMem;
  logic [PTR_BITS-1:0] wrPtr;
  logic [PTR_BITS-1:0] rdPtr;
  logic [PTR_BITS:0]   count;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tagMem <= '0;
      wrPtr  <= '0;
      rdPtr  <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        tagMem[wrPtr] <= pushTag;
        wrPtr         <= wrPtr + PTR_BITS'(1);
      end
      if (pop) begin
        rdPtr <= rdPtr + PTR_BITS'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (PTR_BITS+1)'(1);
        2'b01:   count <= count - (PTR_BITS+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign full  = (count == (PTR_BITS+1)'(DEPTH));
  assign empty = (count == '0);
  assign head  = tagMem[rdPtr];

endmodule

// File: rtl/video_scaler_port_arbiter.sv
// Round-robin shares one scaler between consumer ports A/B and routes returned pixel chunks to the owner.
// Latency: request->slot 1 cycle, pixel pass-through 0 cycles; response stalls both ports when the owner is full.
module video_scaler_port_arbiter
  import video_pipeline_pkg::*;
#(
  parameter int CHUNK_BITS      = CHUNK_BITS_DEFAULT,
  parameter int REQUEST_BITS    = REQUEST_BITS_DEFAULT,
  parameter int BITS_PER_PIXEL  = BITS_PER_PIXEL_DEFAULT,
  parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEFAULT
) (
  input  logic                        scalerClock,
  input  logic                        reset,
  video_scaler_port_arbiter_if.master bus,
  output logic                        protocolError
);

  logic                    slotValid;
  logic [REQUEST_BITS-1:0] slotData;
  logic                    rrLast;
  logic [CHUNK_BITS-1:0]   pixCount;

  logic reqA;
  logic reqB;
  logic grantOk;
  logic grant;
  logic grantOwner;

  logic tagFull;
  logic tagEmpty;
  logic tagHead;
  logic tagPop;
  logic ownerFull;
  logic pixAccept;

  // Grants are held off while reset is low so no consumer FIFO is popped during reset.
  always_comb begin
    reqA    = !bus.portAReqEmpty;
    reqB    = !bus.portBReqEmpty;
    grantOk = reset && (!slotValid || bus.scalerReqReadEnable) && !tagFull;
    if (reqA && reqB) begin
      grantOwner = (rrLast == PORT_A) ? PORT_B : PORT_A;
    end else if (reqB) begin
      grantOwner = PORT_B;
    end else begin
      grantOwner = PORT_A;
    end
    grant = grantOk && (reqA || reqB);
  end

  assign bus.portAReqReadEnable = grant && (grantOwner == PORT_A);
  assign bus.portBReqReadEnable = grant && (grantOwner == PORT_B);
  assign bus.scalerReqEmpty     = !slotValid;
  assign bus.scalerReqReadData  = slotData;

  scaler_owner_tag_fifo #(
    .DEPTH(MAX_OUTSTANDING)
  ) u_tagFifo (
    .clock  (scalerClock),
    .reset  (reset),
    .push   (grant),
    .pushTag(grantOwner),
    .pop    (tagPop),
    .full   (tagFull),
    .empty  (tagEmpty),
    .head   (tagHead)
  );

  // Strict in-order return: a full owner stalls the scaler for both ports.
  assign ownerFull = (tagHead == PORT_B) ? bus.portBRespFull : bus.portARespFull;
  assign bus.scalerRespFull = tagEmpty || ownerFull;
  assign pixAccept = bus.scalerRespWriteEnable && !bus.scalerRespFull;
  assign tagPop    = pixAccept && (pixCount == '1);

  assign bus.portARespWriteEnable = pixAccept && (tagHead == PORT_A);
  assign bus.portBRespWriteEnable = pixAccept && (tagHead == PORT_B);
  assign bus.portARespWriteData   = bus.scalerRespWriteData;
  assign bus.portBRespWriteData   = bus.scalerRespWriteData;

  always_ff @(posedge scalerClock or negedge reset) begin
    if (!reset) begin
      slotValid     <= 1'b0;
      slotData      <= '0;
      rrLast        <= PORT_B;
      pixCount      <= '0;
      protocolError <= 1'b0;
    end else begin
      if (grant) begin
        slotValid <= 1'b1;
        slotData  <= (grantOwner == PORT_B) ? bus.portBReqReadData : bus.portAReqReadData;
        rrLast    <= grantOwner;
      end else if (bus.scalerReqReadEnable) begin
        slotValid <= 1'b0;
      end
      if (pixAccept) begin
        pixCount <= pixCount + CHUNK_BITS'(1);
      end
      if ((bus.scalerReqReadEnable && !slotValid) ||
          (bus.scalerRespWriteEnable && bus.scalerRespFull)) begin
        protocolError <= 1'b1;
      end
    end
  end

endmodule
